crypto_sbox_seq: RTL

//  Sequencer/controller for the shared byte S-box datapath (AES fwd, AES inv, SM4).
//  - Accepts one 32-bit SubWord request with an op select.
//  - Time-multiplexes the 4 bytes over LANES S-box lanes and returns the substituted word.
//  - Sits between the crypto FU issue logic and the S-box layers; valid/ready on both sides.

---
 rtl/crypto_sbox_pkg.sv | 93 +++++++++
 rtl/crypto_sbox_lane.sv | 53 +++++
 rtl/crypto_sbox_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/crypto_sbox_pkg.sv
// Shared types and helpers for the byte S-box sequencer and its lanes.
// CRYPTO_SBOX_SM4_EN: when defined, op 2'b10 selects the SM4 S-box; when
// undefined, SM4 is treated as an illegal op and its layers are not built.
package crypto_sbox_pkg;

  typedef enum logic [1:0] {
    AES_FWD = 2'b00,
    AES_INV = 2'b01,
    SM4     = 2'b10,
    RSVD    = 2'b11
  } sbox_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  // Low bytes of the field polynomials: AES x^8+x^4+x^3+x+1,
  // SM4 x^8+x^7+x^6+x^5+x^4+x^2+1.
  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam logic [7:0] SM4_POLY = 8'hF5;
  localparam logic [7:0] AES_C    = 8'h63;
  localparam logic [7:0] AES_IC   = 8'h05;
  localparam logic [7:0] SM4_C    = 8'hD3;

  // Beats needed to cover four bytes with the given lane count.
  function automatic int nbeats(input int lanes);
    return 32'sd4 / lanes;
  endfunction

  // Beat counter width, never below one bit.
  function automatic int beat_width(input int nb);
    return (nb > 32'sd1) ? $clog2(nb) : 32'sd1;
  endfunction

  function automatic logic is_legal_op(input logic [1:0] op);
`ifdef CRYPTO_SBOX_SM4_EN
    return (op != RSVD);
`else
    return (op == AES_FWD) || (op == AES_INV);
`endif
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int k);
    logic [15:0] d;
    d = {x, x} << k;
    return d[15:8];
  endfunction

  // Carry-less multiply reduced by the polynomial whose low byte is poly.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] poly);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      else      acc = acc;
      if (sh[7]) sh = {sh[6:0], 1'b0} ^ poly;
      else       sh = {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Field inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a, input logic [7:0] poly);
    logic [7:0] res;
    logic [7:0] sq;
    res = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq, poly);
      res = gf_mul(res, sq, poly);
    end
    return res;
  endfunction

  function automatic logic [7:0] aes_affine(input logic [7:0] x);
    return x ^ rol8(x, 1) ^ rol8(x, 2) ^ rol8(x, 3) ^ rol8(x, 4) ^ AES_C;
  endfunction

  function automatic logic [7:0] aes_inv_affine(input logic [7:0] x);
    return rol8(x, 1) ^ rol8(x, 3) ^ rol8(x, 6) ^ AES_IC;
  endfunction

  // SM4 circulant affine: y_i = x_i ^ x_i+1 ^ x_i+2 ^ x_i+5 ^ x_i+7, plus 0xD3.
  function automatic logic [7:0] sm4_affine(input logic [7:0] x);
    return x ^ rol8(x, 7) ^ rol8(x, 6) ^ rol8(x, 3) ^ rol8(x, 1) ^ SM4_C;
  endfunction

endpackage

// File: rtl/crypto_sbox_lane.sv
// One combinational byte S-box lane: op-selected input layer, shared field
// inversion, op-selected output layer. SM4 layers exist only when
// CRYPTO_SBOX_SM4_EN is defined.
module crypto_sbox_lane (
  input  logic [7:0] din,
  input  logic [1:0] op,
  output logic [7:0] dout
);
  import crypto_sbox_pkg::*;

  sbox_op_e   op_sel_s;
  logic [7:0] top_s;
  logic [7:0] poly_s;
  logic [7:0] mid_s;

  assign op_sel_s = sbox_op_e'(op);

  // Input layer and field selection feeding the shared inverter.
  always_comb begin
    top_s  = 8'h00;
    poly_s = AES_POLY;
    case (op_sel_s)
      AES_FWD: top_s = din;
      AES_INV: top_s = aes_inv_affine(din);
`ifdef CRYPTO_SBOX_SM4_EN
      SM4: begin
        top_s  = sm4_affine(din);
        poly_s = SM4_POLY;
      end
`endif
      default: begin
        top_s  = 8'h00;
        poly_s = AES_POLY;
      end
    endcase
  end

  assign mid_s = gf_inv(top_s, poly_s);

  // Output layer matching the selected cipher.
  always_comb begin
    dout = 8'h00;
    case (op_sel_s)
      AES_FWD: dout = aes_affine(mid_s);
      AES_INV: dout = mid_s;
`ifdef CRYPTO_SBOX_SM4_EN
      SM4:     dout = sm4_affine(mid_s);
`endif
      default: dout = 8'h00;
    endcase
  end

endmodule

// File: rtl/crypto_sbox_seq.sv
// Sequencer for the shared byte S-box: takes one 32-bit SubWord request,
// walks its bytes through LANES lanes over NBEATS beats and returns the word.
// CRYPTO_SBOX_SM4_EN enables the SM4 op; otherwise op 2'b10 is illegal.
module crypto_sbox_seq #(
  parameter int LANES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] word_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);
  import crypto_sbox_pkg::*;

  localparam int NBEATS = nbeats(LANES);
  localparam int BW     = beat_width(NBEATS);

  seq_state_e      state_r;
  logic [BW-1:0]   beat_r;
  logic [31:0]     src_r;
  logic [1:0]      op_r;
  logic [31:0]     result_r;
  logic [31:0]     word_r;
  logic            illegal_r;
  logic            valid_r;

  logic            ready_s;
  logic            accept_s;
  logic            last_beat_s;
  logic [31:0]     next_result_s;
  logic [1:0]      lane_idx_s [LANES];
  logic [7:0]      lane_in_s  [LANES];
  logic [7:0]      lane_out_s [LANES];

  // Request-side ready: open in IDLE, follows the consumer in DONE, shut on flush.
  always_comb begin
    ready_s = 1'b0;
    if (flush_i) begin
      ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    ready_s = 1'b1;
        DONE:    ready_s = ready_i;
        default: ready_s = 1'b0;
      endcase
    end
  end

  assign accept_s    = valid_i & ready_s;
  assign last_beat_s = (beat_r == BW'(NBEATS - 1));

  // Byte selection for this beat: lane l takes byte beat*LANES+l.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx_s[l] = 2'(int'(beat_r) * LANES + l);
      lane_in_s[l]  = src_r[{lane_idx_s[l], 3'b000} +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    crypto_sbox_lane u_lane (
      .din  (lane_in_s[g]),
      .op   (op_r),
      .dout (lane_out_s[g])
    );
  end

  // Merge this beat's substituted bytes into the partial result.
  always_comb begin
    next_result_s = result_r;
    for (int l = 0; l < LANES; l++) begin
      next_result_s[{lane_idx_s[l], 3'b000} +: 8] = lane_out_s[l];
    end
  end

  // Sequencer FSM with registered result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      beat_r    <= '0;
      src_r     <= 32'h0000_0000;
      op_r      <= 2'b00;
      result_r  <= 32'h0000_0000;
      word_r    <= 32'h0000_0000;
      illegal_r <= 1'b0;
      valid_r   <= 1'b0;
    end else if (flush_i) begin
      state_r   <= IDLE;
      beat_r    <= '0;
      result_r  <= 32'h0000_0000;
      word_r    <= 32'h0000_0000;
      illegal_r <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        BUSY: begin
          result_r <= next_result_s;
          if (last_beat_s) begin
            state_r   <= DONE;
            beat_r    <= '0;
            word_r    <= next_result_s;
            illegal_r <= 1'b0;
            valid_r   <= 1'b1;
          end else begin
            beat_r <= beat_r + BW'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            state_r   <= IDLE;
            word_r    <= 32'h0000_0000;
            illegal_r <= 1'b0;
            valid_r   <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          beat_r  <= '0;
          valid_r <= 1'b0;
        end
      endcase
      // Accept only happens from IDLE or a consumed DONE, so it overrides the
      // IDLE fallback chosen above in the same cycle (back-to-back issue).
      if (accept_s) begin
        src_r    <= word_i;
        op_r     <= op_i;
        beat_r   <= '0;
        result_r <= 32'h0000_0000;
        if (is_legal_op(op_i)) begin
          state_r   <= BUSY;
          word_r    <= 32'h0000_0000;
          illegal_r <= 1'b0;
          valid_r   <= 1'b0;
        end else begin
          state_r   <= DONE;
          word_r    <= 32'h0000_0000;
          illegal_r <= 1'b1;
          valid_r   <= 1'b1;
        end
      end
    end
  end

  assign ready_o   = ready_s;
  assign valid_o   = valid_r;
  assign word_o    = word_r;
  assign illegal_o = illegal_r;

endmodule
